playlist_sequencer: RTL and testbench
=====================================

Name: playlist_sequencer

Overview:
Controller that sequences the four song ROMs for the music player. It selects the active song, drives the shared ROM read address at the note rate, and inserts a silent gap between songs. It also handles order, random and chosen playback, pause, and next/prev skip requests. Its output is a converted frequency word for the tone generator. Keyboard record and playback modes (3–7) are owned elsewhere; this block idles in those modes.

Parameters:
LEN0, 270, note count of song 0
LEN1, 220, note count of song 1
LEN2, 260, note count of song 2
LEN3, 260, note count of song 3
GAP_TICKS, 12, silent ticks between songs
FREQ_K, 89478, conversion constant (65536/48000 scaled by 2^16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
tick  in  1  one-clk strobe at the note rate (48 Hz)
pause  in  1  1 = hold position, mute output
mode  in  3  0 order, 1 random, 2 choose, 3–7 idle
choice  in  2  song index for mode 2
rand_in  in  2  random song index from the random generator
next_req  in  1  one-clk pulse: skip forward
prev_req  in  1  one-clk pulse: skip back or restart
rom_data  in  16  note data from the selected ROM, 1-clk read latency
rom_addr  out  11  shared ROM read address
song_sel  out  2  ROM mux select
outdata  out  16  converted frequency word
playing  out  1  1 in PLAY state while pause=0
song_done  out  1  one-clk pulse when a song reaches its end

Behaviour:
- One clock. Reset is synchronous and active-low (reset=0 at a clk edge).
- Reset values: state IDLE, rom_addr 0, song_sel 0, outdata 0, playing 0, song_done 0, gap counter 0.
- States: IDLE, PLAY, GAP.
- Selection rule, SEL():
  - mode 0: song_sel+1, wrapping 3→0
  - mode 1: rand_in
  - mode 2: choice
- IDLE:
  - Leave when mode<=2 and pause=0.
  - Go to PLAY with rom_addr=0.
  - song_sel = current song_sel (mode 0), rand_in (mode 1) or choice (mode 2).
- PLAY, on tick with pause=0:
  - If rom_addr < LEN[song_sel]-1: rom_addr+1.
  - Else: go to GAP, song_done=1 for that one cycle, gap counter=0.
- GAP:
  - outdata forced 0.
  - Each tick increments the gap counter.
  - On the tick where the counter reaches GAP_TICKS-1: song_sel=SEL(), rom_addr=0, go to PLAY.
- outdata in PLAY with pause=0, updated every clk:
  - p = rom_data × FREQ_K, 33-bit result.
  - outdata = p[31:16]; saturates to 16'hFFFF if p[32]=1.
  - outdata reflects rom_addr with 2-clk latency (1 clk ROM read + 1 clk register).
- pause=1:
  - State, rom_addr and gap counter are frozen; ticks are ignored.
  - outdata=0 from the next clk; playing=0.
  - Resume continues from the same address.
- next_req in PLAY or GAP:
  - song_sel=SEL(), rom_addr=0, state PLAY next clk, no song_done.
  - Accepted during pause; position updates but stays paused.
- prev_req in PLAY or GAP:
  - mode 0: song_sel-1, wrapping 0→3.
  - modes 1/2: song_sel unchanged.
  - rom_addr=0, state PLAY.
- Simultaneous events:
  - next_req and prev_req: next wins.
  - next/prev and tick: skip wins, tick dropped.
  - song_done and next_req in the same cycle: next wins, no song_done.
- Mode 2 live choice:
  - While in PLAY/GAP with mode=2 and choice≠song_sel: song_sel=choice, rom_addr=0, PLAY on the next clk.
- Other mode changes (among 0/1/2) take effect at the next selection point only.
- mode 3–7: next clk state IDLE, outdata 0, rom_addr 0, song_sel held.
- rom_addr never exceeds LEN[song_sel]-1.

Test Plan:
- Reset, then mode 0, pause 0 → IDLE→PLAY, song_sel 0, rom_addr advances 1 per tick.
  - At addr 269, the next tick gives song_done pulse, then 12 silent ticks, then song_sel 1, addr 0.
- rom_data 0x01B8 (440) steady → outdata 0x0258 (600) two clks after the address.
- rom_data 0xFFFF → outdata 0xFFFF (saturated).
- Pause at addr 100 for 20 ticks → addr stays 100, outdata 0, playing 0; on release resumes at 101 on the next tick.
- Mode 0, song_sel 0: prev_req → song_sel 3, addr 0. next_req and prev_req in the same cycle → song_sel 1.
- Mode 1 with rand_in=2 at end of gap → song_sel 2.
- Mode 2 with choice changed 1→3 mid-song → song_sel 3, addr 0 on the next clk.
- Mode set to 4 mid-song → IDLE, outdata 0, rom_addr 0. Reset asserted mid-GAP → all outputs return to reset values.

Source files
------------

// File: rtl/playlist_sequencer_if.sv
// Playlist sequencer bus.
// Bundles the control inputs, the shared ROM port and the tone-generator
// output of the playlist sequencer so both sides share one port.
//
// Signal semantics: tick, next_req and prev_req are single-clock strobes
// with no backpressure. Each is acted on in the cycle it is high and never
// held or queued. rom_data answers rom_addr one clock later.
//
//   master (sequencer side):
//     in  tick, pause, mode[2:0], choice[1:0], rand_in[1:0],
//         next_req, prev_req, rom_data[15:0]
//     out rom_addr[10:0], song_sel[1:0], outdata[15:0], playing,
//         song_done, state_dbg[1:0]
//   slave (environment side): the same signals with directions reversed.
interface playlist_sequencer_if;
   logic        tick;
   logic        pause;
   logic [2:0]  mode;
   logic [1:0]  choice;
   logic [1:0]  rand_in;
   logic        next_req;
   logic        prev_req;
   logic [15:0] rom_data;
   logic [10:0] rom_addr;
   logic [1:0]  song_sel;
   logic [15:0] outdata;
   logic        playing;
   logic        song_done;
   logic [1:0]  state_dbg;

   modport master (
      input  tick, pause, mode, choice, rand_in, next_req, prev_req, rom_data,
      output rom_addr, song_sel, outdata, playing, song_done, state_dbg
   );

   modport slave (
      output tick, pause, mode, choice, rand_in, next_req, prev_req, rom_data,
      input  rom_addr, song_sel, outdata, playing, song_done, state_dbg
   );
endinterface

// File: rtl/playlist_sequencer.sv
// Playlist sequencer for the music player.
// Selects one of four song ROMs and steps the shared ROM address once per
// note tick. A silent gap is inserted between songs. Order, random and chosen
// playback, pause, and next/prev skips are handled here. The note word read
// back is converted to a frequency word for the tone generator. Modes 3-7
// belong to the keyboard record/playback logic, so in those modes this
// block sits in IDLE.
//
// Ports:
//   clk    system clock
//   reset  synchronous reset, active-low
//   bus    playlist_sequencer_if.master:
//          controls in, ROM address/select out, outdata, playing, song_done,
//          and state_dbg, which is a copy of the FSM state.
module playlist_sequencer #(
   parameter int LEN0      = 270,
   parameter int LEN1      = 220,
   parameter int LEN2      = 260,
   parameter int LEN3      = 260,
   parameter int GAP_TICKS = 12,
   parameter int FREQ_K    = 89478
) (
   input  logic                        clk,
   input  logic                        reset,
   playlist_sequencer_if.master        bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

   logic [1:0]    state;
   logic [10:0]   addr;
   logic [1:0]    sel;
   logic [GW-1:0] gap_cnt;
   logic [15:0]   out_q;
   logic          done_q;

   logic          mode_ok;
   logic [1:0]    sel_next;
   logic [1:0]    sel_prev;
   logic [10:0]   last_addr;
   logic [32:0]   prod;
   logic [15:0]   conv;

   // Modes 0-2 are the playlist modes. Anything higher parks the block.
   assign mode_ok = (bus.mode <= 3'd2);

   // The song picked at a selection point (end of gap, or next_req).
   always_comb begin
      sel_next = sel + 2'd1;
      case (bus.mode)
         3'd1:    sel_next = bus.rand_in;
         3'd2:    sel_next = bus.choice;
         default: sel_next = sel + 2'd1;
      endcase
   end

   // prev_req steps back only in order mode; otherwise it restarts the song.
   assign sel_prev = (bus.mode == 3'd0) ? (sel - 2'd1) : sel;

   always_comb begin
      last_addr = 11'(LEN0 - 1);
      case (sel)
         2'd0:    last_addr = 11'(LEN0 - 1);
         2'd1:    last_addr = 11'(LEN1 - 1);
         2'd2:    last_addr = 11'(LEN2 - 1);
         default: last_addr = 11'(LEN3 - 1);
      endcase
   end

   // Frequency conversion. A 16x17-bit product fits in 33 bits. Bit 32 set
   // means the scaled word overflowed 16 bits, so the word is clamped.
   assign prod = 33'(bus.rom_data) * 33'(FREQ_K);
   assign conv = prod[32] ? 16'hFFFF : prod[31:16];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         addr    <= 11'd0;
         sel     <= 2'd0;
         gap_cnt <= '0;
         out_q   <= 16'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // rom_data here belongs to the address of the previous clock, which
         // gives two clocks from rom_addr to outdata.
         out_q  <= (state == S_PLAY && !bus.pause && mode_ok) ? conv : 16'd0;

         if (state == S_IDLE) begin
            if (mode_ok && !bus.pause) begin
               state   <= S_PLAY;
               addr    <= 11'd0;
               gap_cnt <= '0;
               if (bus.mode == 3'd1)
                  sel <= bus.rand_in;
               else if (bus.mode == 3'd2)
                  sel <= bus.choice;
            end
         end else if (state == S_PLAY || state == S_GAP) begin
            // Priority: mode exit > next > prev > live choice > tick.
            // Skips are accepted while paused. Only the tick is gated by pause.
            if (!mode_ok) begin
               state   <= S_IDLE;
               addr    <= 11'd0;
               gap_cnt <= '0;
            end else if (bus.next_req) begin
               state   <= S_PLAY;
               sel     <= sel_next;
               addr    <= 11'd0;
               gap_cnt <= '0;
            end else if (bus.prev_req) begin
               state   <= S_PLAY;
               sel     <= sel_prev;
               addr    <= 11'd0;
               gap_cnt <= '0;
            end else if (bus.mode == 3'd2 && bus.choice != sel) begin
               state   <= S_PLAY;
               sel     <= bus.choice;
               addr    <= 11'd0;
               gap_cnt <= '0;
            end else if (!bus.pause && bus.tick) begin
               if (state == S_PLAY) begin
                  if (addr < last_addr) begin
                     addr <= addr + 11'd1;
                  end else begin
                     state   <= S_GAP;
                     gap_cnt <= '0;
                     done_q  <= 1'b1;
                  end
               end else if (gap_cnt == GAP_LAST) begin
                  // Counter runs 0..GAP_TICKS-1. Leaving on the tick that
                  // finds it at the top gives GAP_TICKS silent tick periods.
                  state   <= S_PLAY;
                  sel     <= sel_next;
                  addr    <= 11'd0;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
         end else begin
            state   <= S_IDLE;
            addr    <= 11'd0;
            gap_cnt <= '0;
         end
      end
   end

   assign bus.rom_addr  = addr;
   assign bus.song_sel  = sel;
   assign bus.outdata   = out_q;
   assign bus.song_done = done_q;
   assign bus.playing   = (state == S_PLAY) && !bus.pause;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_playlist_sequencer.sv
// Self-checking bench for playlist_sequencer.
// Stimulus is directed first and then randomized. A behavioural model steps
// the playlist rules once per clock and is compared with the DUT on every
// falling edge.
module tb_playlist_sequencer;

   logic clk;
   logic reset;

   playlist_sequencer_if bus ();

   playlist_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ROM stand-in ----------------
   int          lens[4] = '{270, 220, 260, 260};
   bit          force_en  = 1'b0;
   logic [15:0] force_val = 16'd0;

   function automatic logic [15:0] rom_value(input int song, input int addr);
      int v;
      if (force_en) return force_val;
      v = addr * 173 + song * 4099 + 97;
      v = v ^ (addr << 7);
      return v[15:0];
   endfunction

   always @(posedge clk) bus.rom_data <= rom_value(int'(bus.song_sel), int'(bus.rom_addr));

   // ---------------- behavioural model ----------------
   bit          m_active   = 1'b0;   // a song or its trailing gap is in progress
   bit          m_gap      = 1'b0;
   int          m_gap_left = 0;      // ticks of silence still to run
   int          m_addr     = 0;
   int          m_song     = 0;
   logic [15:0] m_rd       = 16'd0;
   logic [15:0] m_out      = 16'd0;
   bit          m_done     = 1'b0;

   function automatic logic [15:0] freq_of(input logic [15:0] d);
      longint p;
      p = longint'(d) * 64'd89478;
      if (p >= 64'h1_0000_0000) return 16'hFFFF;
      return 16'((p >> 16) & 64'hFFFF);
   endfunction

   function automatic int pick_song();
      if (bus.mode == 3'd1) return int'(bus.rand_in);
      if (bus.mode == 3'd2) return int'(bus.choice);
      return (m_song + 1) % 4;
   endfunction

   task automatic start_song(input int s);
      m_song = s;
      m_addr = 0;
      m_gap  = 1'b0;
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         m_active = 1'b0; m_gap = 1'b0; m_addr = 0; m_song = 0;
         m_out = 16'd0; m_done = 1'b0;
         m_rd = rom_value(m_song, m_addr);
      end else begin
         m_out  = (m_active && !m_gap && !bus.pause && bus.mode <= 3'd2) ? freq_of(m_rd) : 16'd0;
         m_rd   = rom_value(m_song, m_addr);
         m_done = 1'b0;
         if (!m_active) begin
            if (bus.mode <= 3'd2 && !bus.pause) begin
               m_active = 1'b1;
               if (bus.mode == 3'd1) start_song(int'(bus.rand_in));
               else if (bus.mode == 3'd2) start_song(int'(bus.choice));
               else start_song(m_song);
            end
         end else if (bus.mode > 3'd2) begin
            m_active = 1'b0; m_gap = 1'b0; m_addr = 0;
         end else if (bus.next_req) begin
            start_song(pick_song());
         end else if (bus.prev_req) begin
            start_song(bus.mode == 3'd0 ? (m_song + 3) % 4 : m_song);
         end else if (bus.mode == 3'd2 && int'(bus.choice) != m_song) begin
            start_song(int'(bus.choice));
         end else if (!bus.pause && bus.tick) begin
            if (m_gap) begin
               m_gap_left--;
               if (m_gap_left == 0) start_song(pick_song());
            end else if (m_addr == lens[m_song] - 1) begin
               m_gap = 1'b1; m_gap_left = 12; m_done = 1'b1;
            end else begin
               m_addr++;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("addr",    32'(bus.rom_addr),  32'(m_addr));
         check("sel",     32'(bus.song_sel),  32'(m_song));
         check("outdata", 32'(bus.outdata),   32'(m_out));
         check("playing", 32'(bus.playing),   32'(m_active && !m_gap && !bus.pause));
         check("done",    32'(bus.song_done), 32'(m_done));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      bus.tick     = 1'b0;
      bus.next_req = 1'b0;
      bus.prev_req = 1'b0;
   endtask

   int done_seen = 0;

   task automatic run_ticks(input int n, input int period);
      for (int i = 0; i < n; i++) begin
         bus.tick = ((i % period) == period - 1);
         step();
         if (bus.song_done) done_seen++;
      end
   endtask

   task automatic wait_gap(input string tag);
      int budget = 400;
      while (!m_gap && budget > 0) begin
         bus.tick = 1'b1;
         step();
         budget--;
      end
      if (budget == 0) check(tag, 32'd0, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      reset        = 1'b0;
      bus.tick     = 1'b0;
      bus.pause    = 1'b0;
      bus.mode     = 3'd0;
      bus.choice   = 2'd0;
      bus.rand_in  = 2'd0;
      bus.next_req = 1'b0;
      bus.prev_req = 1'b0;
      repeat (3) step();
      chk_en = 1'b1;
      check("rst_addr",    32'(bus.rom_addr),  32'd0);
      check("rst_sel",     32'(bus.song_sel),  32'd0);
      check("rst_out",     32'(bus.outdata),   32'd0);
      check("rst_playing", 32'(bus.playing),   32'd0);
      check("rst_done",    32'(bus.song_done), 32'd0);

      // Order mode: song 0 plays out, gap, then song 1.
      reset = 1'b1;
      step();
      check("start_sel",  32'(bus.song_sel), 32'd0);
      check("start_play", 32'(bus.playing),  32'd1);
      run_ticks(600, 2);
      check("end_done_cnt", 32'(done_seen), 32'd1);
      check("after_gap_sel", 32'(bus.song_sel), 32'd1);

      // Frequency conversion, nominal and saturated.
      force_val = 16'h01B8; force_en = 1'b1;
      run_ticks(4, 2);
      check("conv_440", 32'(bus.outdata), 32'h0258);
      force_val = 16'hFFFF;
      run_ticks(4, 2);
      check("conv_sat", 32'(bus.outdata), 32'hFFFF);
      force_en = 1'b0;

      // Pause at address 100 for 20 ticks.
      budget = 300;
      while (m_addr != 100 && budget > 0) begin
         bus.tick = 1'b1;
         step();
         budget--;
      end
      if (budget == 0) check("wait_addr100", 32'd0, 32'd1);
      bus.pause = 1'b1;
      run_ticks(40, 2);
      check("pause_addr",    32'(bus.rom_addr), 32'd100);
      check("pause_out",     32'(bus.outdata),  32'd0);
      check("pause_playing", 32'(bus.playing),  32'd0);
      bus.pause = 1'b0;
      bus.tick  = 1'b1;
      step();
      check("resume_addr", 32'(bus.rom_addr), 32'd101);

      // Skips in order mode.
      bus.prev_req = 1'b1; step();
      check("prev_1to0", 32'(bus.song_sel), 32'd0);
      bus.prev_req = 1'b1; step();
      check("prev_0to3",  32'(bus.song_sel), 32'd3);
      check("prev_addr0", 32'(bus.rom_addr), 32'd0);
      bus.next_req = 1'b1; step();
      bus.next_req = 1'b1; bus.prev_req = 1'b1; step();
      check("next_wins", 32'(bus.song_sel), 32'd1);

      // Random mode picks rand_in at the end of the gap.
      bus.mode = 3'd1; bus.rand_in = 2'd2;
      wait_gap("wait_gap_rand");
      run_ticks(12, 1);
      check("rand_sel",  32'(bus.song_sel), 32'd2);
      check("rand_addr", 32'(bus.rom_addr), 32'd0);

      // Chosen mode follows choice live.
      bus.choice = 2'd2; bus.mode = 3'd2;
      run_ticks(10, 1);
      bus.choice = 2'd1; step();
      run_ticks(30, 1);
      bus.choice = 2'd3; step();
      check("choice_sel",  32'(bus.song_sel), 32'd3);
      check("choice_addr", 32'(bus.rom_addr), 32'd0);

      // Keyboard mode parks the block.
      run_ticks(10, 1);
      bus.mode = 3'd4; step();
      check("idle_addr",    32'(bus.rom_addr), 32'd0);
      check("idle_out",     32'(bus.outdata),  32'd0);
      check("idle_playing", 32'(bus.playing),  32'd0);
      step();
      check("idle_sel_held", 32'(bus.song_sel), 32'd3);

      // Reset in the middle of a gap.
      bus.mode = 3'd0;
      wait_gap("wait_gap_rst");
      run_ticks(3, 1);
      reset = 1'b0; step();
      check("gaprst_addr", 32'(bus.rom_addr),  32'd0);
      check("gaprst_sel",  32'(bus.song_sel),  32'd0);
      check("gaprst_out",  32'(bus.outdata),   32'd0);
      check("gaprst_play", 32'(bus.playing),   32'd0);
      check("gaprst_done", 32'(bus.song_done), 32'd0);
      reset = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 6000; i++) begin
         int r;
         bus.tick     = ($urandom_range(0, 2) == 0);
         bus.next_req = ($urandom_range(0, 199) == 0);
         bus.prev_req = ($urandom_range(0, 199) == 0);
         bus.rand_in  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 2) bus.pause = ~bus.pause;
         if ($urandom_range(0, 149) == 0) bus.choice = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) begin
            r = $urandom_range(0, 9);
            bus.mode = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
         end
         if ($urandom_range(0, 99) == 0) begin
            force_en = ~force_en;
            r = $urandom_range(0, 2);
            force_val = (r == 0) ? 16'h01B8 : (r == 1) ? 16'hFFFF : 16'($urandom_range(0, 65535));
         end
         if ($urandom_range(0, 2999) == 0) reset = 1'b0;
         step();
         reset = 1'b1;
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
